// File: rtl/bls12_381_pkg.sv
// BLS12-381 field parameters shared by the multiplier datapath.
package bls12_381_pkg;

    localparam int unsigned DAT_BITS = 381;

endpackage

// File: rtl/common_pkg.sv
// Shared request type and control-field tag helpers for the multiplier arbiter.
package common_pkg;

    localparam int unsigned CTL_BITS = 16;

    typedef struct packed {
        logic [2*bls12_381_pkg::DAT_BITS-1:0] dat;
        logic [CTL_BITS-1:0]                  ctl;
    } mul_req_t;

    // The requester tag occupies the top $clog2(num_in) bits of the control word.
    function automatic int unsigned tag_lsb(input int unsigned ctl_bits,
                                            input int unsigned num_in);
        return ctl_bits - $clog2(num_in);
    endfunction

endpackage

// File: rtl/rr_arb_sel.sv
// One-hot grant selection: the lowest valid index at or above ptr_i wins, wrapping to index 0.
module rr_arb_sel #(
    parameter int unsigned NUM_IN = 4
) (
    input  logic [NUM_IN-1:0]         val_i,
    input  logic [$clog2(NUM_IN)-1:0] ptr_i,
    output logic [NUM_IN-1:0]         gnt_o
);

    logic [NUM_IN-1:0] mask;
    logic [NUM_IN-1:0] hi;

    assign mask  = ~((NUM_IN'(1) << ptr_i) - NUM_IN'(1));
    assign hi    = val_i & mask;
    // x & -x isolates the lowest set bit
    assign gnt_o = (|hi) ? (hi & (~hi + NUM_IN'(1))) : (val_i & (~val_i + NUM_IN'(1)));

endmodule

// File: rtl/ec_fp_mult_arb.sv
// Shares one modular multiplier among NUM_IN requesters and routes results back by tag.
// Define EC_MULT_ARB_RR_EN for round-robin arbitration; otherwise fixed priority (index 0 first).
module ec_fp_mult_arb
    import common_pkg::*;
#(
    parameter int unsigned NUM_IN   = 4,
    parameter int unsigned DAT_BITS = bls12_381_pkg::DAT_BITS,
    parameter int unsigned CTL_BITS = 16
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic [NUM_IN-1:0][2*DAT_BITS-1:0] i_req_dat,
    input  logic [NUM_IN-1:0][CTL_BITS-1:0]   i_req_ctl,
    input  logic [NUM_IN-1:0]                 i_req_val,
    output logic [NUM_IN-1:0]                 o_req_rdy,
    output logic [2*DAT_BITS-1:0]             o_mul_dat,
    output logic [CTL_BITS-1:0]               o_mul_ctl,
    output logic                              o_mul_val,
    input  logic                              i_mul_rdy,
    input  logic [DAT_BITS-1:0]               i_mul_dat,
    input  logic [CTL_BITS-1:0]               i_mul_ctl,
    input  logic                              i_mul_val,
    output logic                              o_mul_rdy,
    output logic [DAT_BITS-1:0]               o_res_dat,
    output logic [CTL_BITS-1:0]               o_res_ctl,
    output logic [NUM_IN-1:0]                 o_res_val,
    input  logic [NUM_IN-1:0]                 i_res_rdy,
    output logic                              o_err
);

    localparam int unsigned IDX_BITS = $clog2(NUM_IN);
    localparam int unsigned TAG_LSB  = tag_lsb(CTL_BITS, NUM_IN);

    logic                     mul_val_q, mul_val_d;
    logic [2*DAT_BITS-1:0]    mul_dat_q, mul_dat_d;
    logic [CTL_BITS-1:0]      mul_ctl_q, mul_ctl_d;
    logic                     err_q, err_d;
    logic [IDX_BITS-1:0]      ptr;
    logic [NUM_IN-1:0]        gnt;
    logic [IDX_BITS-1:0]      gnt_idx;
    logic [2*DAT_BITS-1:0]    sel_dat;
    logic [TAG_LSB-1:0]       sel_ctl;
    logic [NUM_IN-1:0]        unused_req_tag;
    logic                     reg_free;
    logic                     accept;
    logic [IDX_BITS-1:0]      tag;
    logic                     tag_ok;

    rr_arb_sel #(
        .NUM_IN(NUM_IN)
    ) u_sel (
        .val_i(i_req_val),
        .ptr_i(ptr),
        .gnt_o(gnt)
    );

    always_comb begin
        gnt_idx        = '0;
        sel_dat        = '0;
        sel_ctl        = '0;
        unused_req_tag = '0;
        for (int unsigned k = 0; k < NUM_IN; k++) begin
            unused_req_tag[k] = ^i_req_ctl[k][CTL_BITS-1:TAG_LSB];
            if (gnt[k]) begin
                gnt_idx = IDX_BITS'(k);
                sel_dat = i_req_dat[k];
                sel_ctl = i_req_ctl[k][TAG_LSB-1:0];
            end
        end
    end

    assign reg_free  = !mul_val_q || i_mul_rdy;
    assign o_req_rdy = (i_rst && reg_free) ? gnt : '0;
    assign accept    = |o_req_rdy;

    always_comb begin
        mul_val_d = mul_val_q;
        mul_dat_d = mul_dat_q;
        mul_ctl_d = mul_ctl_q;
        if (reg_free) begin
            mul_val_d = accept;
            if (accept) begin
                mul_dat_d = sel_dat;
                mul_ctl_d = {gnt_idx, sel_ctl};
            end
        end
    end

`ifdef EC_MULT_ARB_RR_EN
    logic [IDX_BITS-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (accept) begin
            ptr_d = (gnt_idx == IDX_BITS'(NUM_IN - 1)) ? '0 : gnt_idx + IDX_BITS'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;
`else
    assign ptr = '0;
`endif

    // Result routing is purely combinational; out-of-range tags are swallowed.
    assign tag       = i_mul_ctl[CTL_BITS-1 -: IDX_BITS];
    assign tag_ok    = 32'(tag) < NUM_IN;
    assign o_res_dat = i_mul_dat;
    assign o_res_ctl = i_mul_ctl;

    always_comb begin
        o_res_val = '0;
        o_mul_rdy = 1'b1;
        for (int unsigned k = 0; k < NUM_IN; k++) begin
            if (tag == IDX_BITS'(k)) begin
                o_res_val[k] = i_mul_val;
                o_mul_rdy    = i_res_rdy[k];
            end
        end
    end

    assign err_d = err_q | (i_mul_val & ~tag_ok);

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            mul_val_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            mul_val_q <= mul_val_d;
            err_q     <= err_d;
        end
    end

    always_ff @(posedge i_clk) begin
        mul_dat_q <= mul_dat_d;
        mul_ctl_q <= mul_ctl_d;
    end

    assign o_mul_val = mul_val_q;
    assign o_mul_dat = mul_dat_q;
    assign o_mul_ctl = mul_ctl_q;
    assign o_err     = err_q;

endmodule

// File: tb/tb_ec_fp_mult_arb.sv
// Directed bench for ec_fp_mult_arb: arbitration, stall, result routing and tag-error flag.
module tb_ec_fp_mult_arb;

    localparam int unsigned DB = bls12_381_pkg::DAT_BITS;

    logic                   clk;
    logic                   rst;
    logic [3:0][2*DB-1:0]   req_dat;
    logic [3:0][15:0]       req_ctl;
    logic [3:0]             req_val;
    logic [3:0]             req_rdy;
    logic [2*DB-1:0]        mul_dat_o;
    logic [15:0]            mul_ctl_o;
    logic                   mul_val_o;
    logic                   mul_rdy_i;
    logic [DB-1:0]          mul_dat_i;
    logic [15:0]            mul_ctl_i;
    logic                   mul_val_i;
    logic                   mul_rdy_o;
    logic [DB-1:0]          res_dat;
    logic [15:0]            res_ctl;
    logic [3:0]             res_val;
    logic [3:0]             res_rdy;
    logic                   err;

    logic                   b_rst;
    logic [2:0][31:0]       b_req_dat;
    logic [2:0][15:0]       b_req_ctl;
    logic [2:0]             b_req_val;
    logic [2:0]             b_req_rdy;
    logic [31:0]            b_mul_dat_o;
    logic [15:0]            b_mul_ctl_o;
    logic                   b_mul_val_o;
    logic                   b_mul_rdy_i;
    logic [15:0]            b_mul_dat_i;
    logic [15:0]            b_mul_ctl_i;
    logic                   b_mul_val_i;
    logic                   b_mul_rdy_o;
    logic [15:0]            b_res_dat;
    logic [15:0]            b_res_ctl;
    logic [2:0]             b_res_val;
    logic [2:0]             b_res_rdy;
    logic                   b_err;

    int n_checks = 0;
    int n_errors = 0;
    int exp_tag [6];

    ec_fp_mult_arb #(
        .NUM_IN(4)
    ) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_req_dat(req_dat),
        .i_req_ctl(req_ctl),
        .i_req_val(req_val),
        .o_req_rdy(req_rdy),
        .o_mul_dat(mul_dat_o),
        .o_mul_ctl(mul_ctl_o),
        .o_mul_val(mul_val_o),
        .i_mul_rdy(mul_rdy_i),
        .i_mul_dat(mul_dat_i),
        .i_mul_ctl(mul_ctl_i),
        .i_mul_val(mul_val_i),
        .o_mul_rdy(mul_rdy_o),
        .o_res_dat(res_dat),
        .o_res_ctl(res_ctl),
        .o_res_val(res_val),
        .i_res_rdy(res_rdy),
        .o_err    (err)
    );

    ec_fp_mult_arb #(
        .NUM_IN  (3),
        .DAT_BITS(16)
    ) dut3 (
        .i_clk    (clk),
        .i_rst    (b_rst),
        .i_req_dat(b_req_dat),
        .i_req_ctl(b_req_ctl),
        .i_req_val(b_req_val),
        .o_req_rdy(b_req_rdy),
        .o_mul_dat(b_mul_dat_o),
        .o_mul_ctl(b_mul_ctl_o),
        .o_mul_val(b_mul_val_o),
        .i_mul_rdy(b_mul_rdy_i),
        .i_mul_dat(b_mul_dat_i),
        .i_mul_ctl(b_mul_ctl_i),
        .i_mul_val(b_mul_val_i),
        .o_mul_rdy(b_mul_rdy_o),
        .o_res_dat(b_res_dat),
        .o_res_ctl(b_res_ctl),
        .o_res_val(b_res_val),
        .i_res_rdy(b_res_rdy),
        .o_err    (b_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2*DB-1:0] req_word(input int k);
        return {DB'(32'h2000 + k), DB'(32'h1000 + k)};
    endfunction

    // Control word after the arbiter writes tag t over the top two bits of requester k's ctl.
    function automatic logic [15:0] tagged_ctl(input int t, input int k);
        return 16'((t << 14) | (32'h00A0 + k));
    endfunction

    task automatic chk(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
`ifdef EC_MULT_ARB_RR_EN
        exp_tag = '{0, 1, 2, 3, 0, 1};
`else
        exp_tag = '{0, 0, 0, 0, 0, 0};
`endif
        rst       = 1'b0;
        req_val   = 4'b1111;
        mul_rdy_i = 1'b1;
        mul_val_i = 1'b0;
        mul_ctl_i = '0;
        mul_dat_i = '0;
        res_rdy   = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            req_dat[k] = req_word(k);
            req_ctl[k] = 16'(32'hC0A0 + k);
        end
        b_rst       = 1'b0;
        b_req_dat   = '0;
        b_req_ctl   = '0;
        b_req_val   = '0;
        b_mul_rdy_i = 1'b1;
        b_mul_dat_i = '0;
        b_mul_ctl_i = '0;
        b_mul_val_i = 1'b0;
        b_res_rdy   = 3'b111;

        tick();
        tick();
        chk("rst_mul_val", mul_val_o, 0);
        chk("rst_req_rdy", req_rdy, 0);
        chk("rst_err", err, 0);

        // All four request continuously with the multiplier always ready.
        rst = 1'b1;
        #1;
        chk("rot_rdy0", req_rdy, 4'b0001);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("rot_val%0d", i), mul_val_o, 1);
            chk($sformatf("rot_ctl%0d", i), mul_ctl_o, tagged_ctl(exp_tag[i], exp_tag[i]));
            chk($sformatf("rot_dat%0d", i), mul_dat_o, req_word(exp_tag[i]));
        end
        req_val = 4'b0000;
        tick();
        chk("drain_val", mul_val_o, 0);
        rst = 1'b0;
        tick();
        rst = 1'b1;

`ifndef EC_MULT_ARB_RR_EN
        req_val = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("starve_rdy%0d", i), req_rdy, 4'b0010);
            tick();
            chk($sformatf("starve_ctl%0d", i), mul_ctl_o, tagged_ctl(1, 1));
            chk($sformatf("starve_dat%0d", i), mul_dat_o, req_word(1));
        end
`endif
        req_val = 4'b1000;
        #1;
        chk("p3_rdy", req_rdy, 4'b1000);
        tick();
        chk("p3_ctl", mul_ctl_o, tagged_ctl(3, 3));

        // Stall the multiplier; the held request must not change even if inputs do.
        mul_rdy_i  = 1'b0;
        req_val    = 4'b1111;
        req_dat[3] = req_word(7);
        #1;
        chk("stall_rdy_pre", req_rdy, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("stall_val%0d", i), mul_val_o, 1);
            chk($sformatf("stall_ctl%0d", i), mul_ctl_o, tagged_ctl(3, 3));
            chk($sformatf("stall_dat%0d", i), mul_dat_o, req_word(3));
            chk($sformatf("stall_rdy%0d", i), req_rdy, 0);
        end
        mul_rdy_i = 1'b1;
        #1;
        chk("rel_rdy", req_rdy, 4'b0001);
        tick();
        chk("rel_val", mul_val_o, 1);
        chk("rel_ctl", mul_ctl_o, tagged_ctl(0, 0));
        chk("rel_dat", mul_dat_o, req_word(0));
        req_val    = 4'b0000;
        req_dat[3] = req_word(3);
        #1;
        chk("idle_rdy", req_rdy, 0);
        tick();
        chk("idle_val", mul_val_o, 0);

        // Result with tag 2 back-pressured by its requester.
        mul_dat_i = DB'(32'h1234);
        mul_ctl_i = 16'h80AB;
        mul_val_i = 1'b1;
        res_rdy   = 4'b1011;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("res_val%0d", i), res_val, 4'b0100);
            chk($sformatf("res_mrdy%0d", i), mul_rdy_o, 0);
            chk($sformatf("res_ctl%0d", i), res_ctl, 16'h80AB);
            chk($sformatf("res_dat%0d", i), res_dat, 32'h1234);
            tick();
        end
        res_rdy = 4'b1111;
        #1;
        chk("res_done_mrdy", mul_rdy_o, 1);
        chk("res_done_val", res_val, 4'b0100);
        tick();
        mul_ctl_i = 16'h0001;
        #1;
        chk("res_tag0_val", res_val, 4'b0001);
        mul_val_i = 1'b0;
        #1;
        chk("res_none_val", res_val, 0);
        chk("err_clean", err, 0);

        // NUM_IN=3 instance: tag 3 is out of range.
        b_rst = 1'b1;
        tick();
        chk("b_err_init", b_err, 0);
        b_mul_ctl_i = 16'hC001;
        b_mul_val_i = 1'b1;
        #1;
        chk("b_drop_val", b_res_val, 3'b000);
        chk("b_drop_rdy", b_mul_rdy_o, 1);
        tick();
        b_mul_val_i = 1'b0;
        chk("b_err_set", b_err, 1);
        tick();
        tick();
        chk("b_err_sticky", b_err, 1);
        b_mul_ctl_i = 16'h8000;
        b_mul_val_i = 1'b1;
        b_res_rdy   = 3'b100;
        #1;
        chk("b_tag2_val", b_res_val, 3'b100);
        chk("b_tag2_rdy", b_mul_rdy_o, 1);
        b_mul_val_i = 1'b0;
        b_rst       = 1'b0;
        tick();
        chk("b_err_clr", b_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ec_fp_mult_arb.md
EC_FP_MULT_ARB -- requirements
Module: ec_fp_mult_arb

Interface
REQ-001 Parameter NUM_IN, default 4: number of requesters sharing one modular multiplier; legal range 2..8.
REQ-002 Parameter DAT_BITS, default 381: operand width, equal to bls12_381_pkg::DAT_BITS.
REQ-003 Parameter CTL_BITS, default 16: control width on both sides; the top IDX_BITS=$clog2(NUM_IN) bits are reserved for the requester tag.
REQ-004 i_clk  in  1  single clock; all logic is on its rising edge.
REQ-005 i_rst  in  1  reset, synchronous and active-low.
REQ-006 i_req_dat  in  NUM_IN x 2*DAT_BITS  operands; a in bits [DAT_BITS-1:0], b in the upper half.
REQ-007 i_req_ctl  in  NUM_IN x CTL_BITS  requester control; the top IDX_BITS bits are ignored.
REQ-008 i_req_val / o_req_rdy  in / out  NUM_IN  per-requester valid/ready.
REQ-009 o_mul_dat, o_mul_ctl, o_mul_val / i_mul_rdy  out / in  2*DAT_BITS, CTL_BITS, 1 / 1  request to the multiplier.
REQ-010 i_mul_dat, i_mul_ctl, i_mul_val / o_mul_rdy  in / out  DAT_BITS, CTL_BITS, 1 / 1  result from the multiplier.
REQ-011 o_res_dat, o_res_ctl  out  DAT_BITS, CTL_BITS  result broadcast to every requester.
REQ-012 o_res_val / i_res_rdy  out / in  NUM_IN  per-requester result valid/ready.
REQ-013 o_err  out  1  sticky flag: a result arrived with an out-of-range tag.

Function
REQ-014 A transfer occurs on any interface when val and rdy are both 1 on the same rising edge.
REQ-015 The request path SHALL use a single output register (o_mul_*); the register is free when o_mul_val=0 or i_mul_rdy=1.
REQ-016 Each cycle, at most one requester with i_req_val=1 SHALL be granted; o_req_rdy is 1 only for the granted index, and only while the output register is free.
REQ-017 On a transfer, the register SHALL load the requester's dat, and its ctl with the top IDX_BITS bits replaced by the grant index; o_mul_val rises the next cycle, giving 1-cycle request latency.
REQ-018 Back-to-back operation: with i_mul_rdy held at 1, one request SHALL be accepted every cycle, with no bubble.
REQ-019 While o_mul_val=1 and i_mul_rdy=0, o_mul_dat and o_mul_ctl SHALL stay stable and every o_req_rdy SHALL be 0.
REQ-020 The result path SHALL be combinational: o_res_dat=i_mul_dat, o_res_ctl=i_mul_ctl, o_res_val[k]=i_mul_val when tag==k, o_mul_rdy=i_res_rdy[tag].
REQ-021 If tag>=NUM_IN, the result SHALL be dropped (o_mul_rdy=1, all o_res_val=0) and o_err SHALL be set until reset.
REQ-022 The multiplier is in-order; the block SHALL keep no per-request state beyond the arbitration pointer.
REQ-023 A grant SHALL depend only on current i_req_val and the pointer; requesters need not hold val to win.

Reset
REQ-024 While i_rst=0 at a clock edge: o_mul_val=0, o_err=0, pointer=0; o_mul_dat and o_mul_ctl hold don't-care values.
REQ-025 Reset mid-operation SHALL discard the registered request; results still in flight from the multiplier are the integrator's responsibility and need not be routed.
REQ-026 During reset, all o_req_rdy SHALL be 0.

Configuration
REQ-027 With macro EC_MULT_ARB_RR_EN defined: round-robin; search starts at the pointer, and after each accepted transfer the pointer becomes (grant+1) mod NUM_IN.
REQ-028 Without EC_MULT_ARB_RR_EN: fixed priority; the lowest valid index wins, and the pointer register is not built.

Structure
REQ-029 The tag-position helper and a request typedef {dat, ctl} SHALL live in common_pkg; DAT_BITS comes from bls12_381_pkg.
REQ-030 Grant selection SHALL be one sub-module, rr_arb_sel (inputs: val vector and pointer; output: one-hot grant), shared by both modes, with pointer fixed at 0 when EC_MULT_ARB_RR_EN is not defined.

Verification
REQ-031 NUM_IN=4, RR: all four request every cycle and i_mul_rdy=1 -> grants 0,1,2,3,0,1 on consecutive cycles; tags match.
REQ-032 Fixed priority: requesters 1 and 3 hold val -> requester 1 is served every cycle and 3 starves until 1 drops val.
REQ-033 i_mul_rdy=0 for 5 cycles with o_mul_val=1 -> o_mul_dat/ctl are unchanged and all o_req_rdy=0; on release, one transfer occurs next edge.
REQ-034 Multiplier result with tag 2, ctl low bits 0x0AB, i_res_rdy[2]=0 for 3 cycles -> o_res_val=4'b0100 held, o_mul_rdy=0, then completes.
REQ-035 NUM_IN=3, a result with tag 3 -> dropped, o_err=1 and stays 1 until i_rst=0.
REQ-036 End-to-end with ec_fp_mult_mod: 3 requesters each issue 20 random operand pairs -> every requester receives (a*b) mod P, in its own issue order.
